// File: rtl/quadratic_solver_arbiter.sv
// quadratic_solver_arbiter
//  Shares one pipelined quadratic solver, x0 = (-b - sqrt(b*b - 4c)) / 2, among N_REQ
//  requesters. A round-robin arbiter accepts at most one (b,c) pair per cycle. A tag pipeline
//  runs alongside the solver so that each result goes back to the requester that issued it.
//  Per-requester credit counters limit how much work each requester can have in flight.
//
//  fp24 format: {sign, exp[7:0] (bias 127), frac[14:0]}. This is the upper 24 bits of IEEE
//  float32. Zero is encoded with exp == 0, and denormals are flushed to zero. Inside the
//  solver, values are converted to signed Q16.16 fixed point. Operands and roots must
//  therefore satisfy |v| < 2^15, and results are truncated to a resolution of 2^-16.
//
//  Optional build macro: QSOLVE_ARB_STATS_EN adds the grant_count and credit_stall_count ports.
//
// Ports
//  clk                 system clock
//  rst                 synchronous reset, active-high
//  req_valid[N]        requester i has a (b,c) pair pending
//  req_ready[N]        one-hot grant; a transfer happens when req_valid[i] & req_ready[i]
//  req_b/req_c[N*24]   fp24 operands; requester i occupies [24*i +: 24]
//  res_valid[N]        one-hot, or zero: a result for requester i this cycle
//  res_x0[24]          fp24 nearer root; meaningful only when res_hit = 1
//  res_hit             discriminant >= 0
//  busy                at least one request is in flight
//  grant_count[N*16]   (stats build) per-requester accept counts, saturating
//  credit_stall_count  (stats build) cycles in which a valid request was blocked only by
//                      its credit limit, saturating
module quadratic_solver_arbiter #(
   parameter int N_REQ           = 4,
   parameter int SOLVER_LATENCY  = 16,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_valid,
   output logic [N_REQ-1:0]    req_ready,
   input  logic [N_REQ*24-1:0] req_b,
   input  logic [N_REQ*24-1:0] req_c,
   output logic [N_REQ-1:0]    res_valid,
   output logic [23:0]         res_x0,
   output logic                res_hit,
   output logic                busy
`ifdef QSOLVE_ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0] grant_count,
   output logic [15:0]         credit_stall_count
`endif
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
   localparam int L = SOLVER_LATENCY;

   logic [PW-1:0] ptr, ptr_next, gidx, scan_idx;
   logic          found;
   logic [CW-1:0] outstanding [N_REQ];
   logic [N_REQ-1:0] eligible, credit_blocked;

   logic [23:0]   issue_b, issue_c;
   logic          issue_v;
   logic [PW-1:0] issue_id;

   logic          tag_v    [L];
   logic [PW-1:0] tag_id   [L];
   logic [23:0]   x0_pipe  [L];
   logic          hit_pipe [L];

   logic signed [31:0] b_fix, c_fix;
   logic signed [63:0] bb, disc;
   logic [31:0]        root;
   logic signed [33:0] num;
   logic [23:0]        sol_x0;
   logic               sol_hit;

   function automatic logic [31:0] fp_to_fix(input logic [23:0] f);
      logic [31:0] mag;
      int sh;
      mag = {16'd0, 1'b1, f[14:0]};
      sh  = int'(f[22:15]) - 126;
      if (f[22:15] == 8'd0 || sh > 15 || sh < -16) mag = '0;
      else if (sh >= 0)                            mag = mag << sh;
      else                                         mag = mag >> (-sh);
      return f[23] ? -mag : mag;
   endfunction

   function automatic logic [31:0] isqrt(input logic [63:0] v);
      logic [31:0] r, cand;
      r = '0;
      for (int i = 31; i >= 0; i--) begin
         cand = r | (32'd1 << i);
         if (64'(cand) * 64'(cand) <= v) r = cand;
      end
      return r;
   endfunction

   function automatic logic [23:0] fix_to_fp(input logic signed [33:0] x);
      logic [33:0] a, n;
      int p;
      a = x[33] ? 34'(-x) : 34'(x);
      p = -1;
      for (int i = 0; i < 34; i++) if (a[i]) p = i;
      if (p < 0) return '0;
      n = a << (33 - p);
      return {x[33], 8'(p + 111), n[32:18]};
   endfunction

   // A requester whose result is returning this cycle gets its credit back in the same cycle.
   // Without this, a requester sitting at its credit limit would lose a grant slot.
   always_comb begin
      for (int i = 0; i < N_REQ; i++)
         eligible[i] = req_valid[i] & ((outstanding[i] < MAX_CNT) | res_valid[i]);
      credit_blocked = req_valid & ~eligible;
   end

   always_comb begin
      req_ready = '0;
      gidx      = '0;
      found     = 1'b0;
      scan_idx  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = PW'((int'(ptr) + k) % N_REQ);
         if (!found && eligible[scan_idx]) begin
            req_ready[scan_idx] = 1'b1;
            gidx                = scan_idx;
            found               = 1'b1;
         end
      end
      ptr_next = (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         res_valid[i] = tag_v[L-1] && (tag_id[L-1] == PW'(i));
         busy         = busy | (outstanding[i] != '0);
      end
      res_x0  = x0_pipe[L-1];
      res_hit = hit_pipe[L-1];
   end

   // The solver arithmetic is evaluated in one stage; the remaining latency is made up by the
   // delay line, so results stay aligned with the tag pipe.
   always_comb begin
      b_fix   = fp_to_fix(issue_b);
      c_fix   = fp_to_fix(issue_c);
      bb      = b_fix * b_fix;
      disc    = bb - (64'(c_fix) <<< 18);
      sol_hit = ~disc[63];
      root    = isqrt(sol_hit ? $unsigned(disc) : 64'd0);
      num     = -34'(b_fix) - $signed({2'b00, root});
      sol_x0  = fix_to_fp(num >>> 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= '0;
         issue_b  <= '0;
         issue_c  <= '0;
         issue_v  <= 1'b0;
         issue_id <= '0;
         for (int i = 0; i < N_REQ; i++) outstanding[i] <= '0;
         for (int s = 0; s < L; s++) begin
            tag_v[s]    <= 1'b0;
            tag_id[s]   <= '0;
            x0_pipe[s]  <= '0;
            hit_pipe[s] <= 1'b0;
         end
      end else begin
         if (found) begin
            ptr      <= ptr_next;
            issue_b  <= req_b[24*gidx +: 24];
            issue_c  <= req_c[24*gidx +: 24];
            issue_v  <= 1'b1;
            issue_id <= gidx;
         end else begin
            issue_b  <= '0;
            issue_c  <= '0;
            issue_v  <= 1'b0;
            issue_id <= '0;
         end
         tag_v[0]    <= issue_v;
         tag_id[0]   <= issue_id;
         x0_pipe[0]  <= issue_v ? sol_x0 : '0;
         hit_pipe[0] <= issue_v & sol_hit;
         for (int s = 1; s < L; s++) begin
            tag_v[s]    <= tag_v[s-1];
            tag_id[s]   <= tag_id[s-1];
            x0_pipe[s]  <= x0_pipe[s-1];
            hit_pipe[s] <= hit_pipe[s-1];
         end
         for (int i = 0; i < N_REQ; i++) begin
            case ({req_ready[i], res_valid[i]})
               2'b10:   outstanding[i] <= outstanding[i] + 1'b1;
               2'b01:   outstanding[i] <= outstanding[i] - 1'b1;
               default: outstanding[i] <= outstanding[i];
            endcase
         end
      end
   end

`ifdef QSOLVE_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_count        <= '0;
         credit_stall_count <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++)
            if (req_ready[i] && grant_count[16*i +: 16] != 16'hFFFF)
               grant_count[16*i +: 16] <= grant_count[16*i +: 16] + 16'd1;
         if (|credit_blocked && credit_stall_count != 16'hFFFF)
            credit_stall_count <= credit_stall_count + 16'd1;
      end
   end
`endif

endmodule
